bist_signature_analyzer: RTL and testbench
==========================================

# bist_signature_analyzer

Response-side companion to the built-in self-test scan chain. Consumes the serial `scan_out` stream that the chain produces under `scan_en`, compacts it into a serial-input signature register (SISR), and compares the final signature against a golden value. Sits at the output end of the BIST path, alongside the LFSR pattern source and scan chain, and gives a single pass/fail verdict per test session.

## Interface
Parameters:
- `CHAIN_LEN`, 8: scan chain length; shift cycles per window.
- `NUM_PATTERNS`, 8: number of captured responses compacted per session.
- `SIG_WIDTH`, 8: signature register width.
- `POLY`, 8'h1D: SISR feedback taps (x^8+x^4+x^3+x^2+1), `SIG_WIDTH` bits.
- `GOLDEN`, 8'h00: expected final signature, `SIG_WIDTH` bits.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `start` in 1: session start pulse; honoured only in IDLE or DONE.
- `scan_en` in 1: chain shift enable (1 = shift, 0 = capture/hold).
- `scan_out` in 1: serial data out of the scan chain.
- `busy` out 1: session in progress.
- `done` out 1: session finished; held until `start` or `rst`.
- `pass` out 1: valid when `done`; 1 iff no error and signature == `GOLDEN`.
- `err` out 1: protocol violation detected; held until `start` or `rst`.
- `signature` out `SIG_WIDTH`: current SISR contents.

## Operation
- States: IDLE, SHIFT, CAPTURE, DONE.
- IDLE: `scan_en`/`scan_out` ignored. `start`=1 → SHIFT; clears signature, window counter, bit counter, `done`, `pass`, `err`.
- Window = `CHAIN_LEN` consecutive clock edges with `scan_en`=1. Session = windows 0..`NUM_PATTERNS` (`NUM_PATTERNS`+1 windows).
- Window 0 unloads pre-test chain contents: bits counted, not compacted. Windows 1..`NUM_PATTERNS` are compacted.
- SHIFT: each edge with `scan_en`=1 samples `scan_out`, increments bit counter. In compacted windows: fb = signature[MSB] ^ `scan_out`; signature ← (signature << 1) ^ (fb ? `POLY` : 0).
- SHIFT, `scan_en`=0 before bit counter reaches `CHAIN_LEN`: protocol error → DONE; `err`=1, `pass`=0, `done`=1. Signature frozen.
- End of window (`CHAIN_LEN`th bit sampled): if window == `NUM_PATTERNS` → DONE; else → CAPTURE, bit counter cleared, window counter +1.
- CAPTURE: any number of `scan_en`=0 cycles is legal (capture plus holds). First edge with `scan_en`=1 → SHIFT, and that edge's `scan_out` is bit 0 of the next window.
- DONE: `done`=1, `pass` = (signature == `GOLDEN`) && !`err`. `start`=1 → restart exactly as from IDLE. `start` in SHIFT/CAPTURE ignored.
- `busy` = state is SHIFT or CAPTURE.
- `rst` at any time (including mid-window): IDLE, all outputs 0, counters 0, on that edge. Takes precedence over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err`=0, `signature`=0.
- All outputs registered; visible the cycle after the causing edge.
- `start` edge → `busy`=1 next cycle. The first sampled bit is the first `scan_en`=1 edge at or after the cycle following `start`.
- Last bit of window `NUM_PATTERNS` sampled at edge N → `busy`=0, `done`=1, `pass` valid from cycle N+1. No extra compare latency.
- Nominal session (defaults, no holds): 9×8 shift edges + 8 capture cycles = 80 cycles from first shift to `done`.
- Error detection: `done`/`err` rise the cycle after the offending `scan_en`=0 edge.

## Test plan
- Reset: hold `rst`=1 two cycles with `start`=1, `scan_en`=1 → all outputs 0, state IDLE. `scan_en` activity with no `start` → `signature` stays 0x00.
- All-zero response, `GOLDEN`=0x00: `start`, then 9 windows of 8 shifts separated by one `scan_en`=0 cycle, `scan_out`=0 → `done`=1, `pass`=1, `err`=0, `signature`=0x00; `done` held 10 further cycles.
- Discard plus single-bit compaction: window 0 `scan_out`=1 for all bits; window 1 bit 0 =1, rest 0 → `signature`=0x00 during CAPTURE after window 0; 0x1D after window 1 bit 0; 0x26 during the CAPTURE after window 1. Remaining windows all zero, `GOLDEN`=0x00 → `pass`=0.
- Protocol error: `scan_en` drops after 5 shifts of window 2 → next cycle `err`=1, `done`=1, `pass`=0, `busy`=0, `signature` frozen.
- Reset mid-session: `rst` pulse during window 3 → next cycle all outputs 0. Later shifting without `start` leaves `signature` at 0x00.
- Start handling: `start` pulses during SHIFT and CAPTURE → no effect on counters or `signature`. `start` in DONE → `done`/`pass` clear, `signature`=0x00, new session completes normally.

Source files
------------

// File: rtl/bist_signature_analyzer.sv
// bist_signature_analyzer
//   Compacts the serial response stream of the BIST scan chain into a
//   serial-input signature register (SISR). At the end of the session it
//   compares the signature with GOLDEN and gives one pass/fail verdict.
//   Window 0 unloads the pre-test chain contents. Its bits are counted but
//   not compacted. Windows 1..NUM_PATTERNS are compacted.
// Ports
//   clk       in  system clock, rising edge
//   rst       in  synchronous active-high reset
//   start     in  session start pulse (honoured in IDLE or DONE only)
//   scan_en   in  chain shift enable (1 = shift, 0 = capture/hold)
//   scan_out  in  serial data out of the scan chain
//   busy      out session in progress (SHIFT or CAPTURE)
//   done      out session finished, held until start or rst
//   pass      out 1 iff done, no error, and signature == GOLDEN
//   err       out scan_en dropped mid-window, held until start or rst
//   signature out current SISR contents
module bist_signature_analyzer #(
  parameter int unsigned           CHAIN_LEN    = 8,
  parameter int unsigned           NUM_PATTERNS = 8,
  parameter int unsigned           SIG_WIDTH    = 8,
  parameter logic [SIG_WIDTH-1:0]  POLY         = 8'h1D,
  parameter logic [SIG_WIDTH-1:0]  GOLDEN       = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 scan_en,
  input  logic                 scan_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int unsigned BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned WIN_W = $clog2(NUM_PATTERNS + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHIFT   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]           state, state_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [WIN_W-1:0]     win_cnt, win_cnt_d;
  logic [SIG_WIDTH-1:0] sig_d, sig_shift;
  logic                 busy_d, done_d, pass_d, err_d;
  logic                 fb;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      win_cnt   <= '0;
      signature <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      win_cnt   <= win_cnt_d;
      signature <= sig_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      err       <= err_d;
    end
  end

  // Next-state, counter, SISR and verdict logic
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    win_cnt_d = win_cnt;
    sig_d     = signature;
    done_d    = done;
    pass_d    = pass;
    err_d     = err;

    fb        = signature[SIG_WIDTH-1] ^ scan_out;
    sig_shift = {signature[SIG_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_SHIFT;
          bit_cnt_d = '0;
          win_cnt_d = '0;
          sig_d     = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = 1'b0;
        end
      end

      // CAPTURE shares the shift path: its first scan_en=1 edge is bit 0
      // of the next window (bit_cnt is already 0 there).
      S_SHIFT, S_CAPTURE: begin
        if (scan_en) begin
          state_d = S_SHIFT;
          if (win_cnt != '0) sig_d = sig_shift;
          if (bit_cnt == BIT_W'(CHAIN_LEN - 1)) begin
            if (win_cnt == WIN_W'(NUM_PATTERNS)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              pass_d  = (sig_d == GOLDEN);
            end else begin
              state_d   = S_CAPTURE;
              bit_cnt_d = '0;
              win_cnt_d = win_cnt + WIN_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end else if (state == S_SHIFT) begin
          // Short window: the chain stopped before all bits were unloaded
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT) || (state_d == S_CAPTURE);
  end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer with default parameters.
module tb_bist_signature_analyzer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       scan_en = 1'b0;
  logic       scan_out = 1'b0;
  logic       busy, done, pass, err;
  logic [7:0] signature;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;
  logic [7:0]  exp_sig;
  logic [7:0]  frozen;
  logic [7:0]  pat;

  bist_signature_analyzer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .scan_en   (scan_en),
    .scan_out  (scan_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err       (err),
    .signature (signature)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference SISR step for x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] sisr(input logic [7:0] s, input logic b);
    logic f;
    f = s[7] ^ b;
    return {s[6:0], 1'b0} ^ {3'b000, f, f, f, 1'b0, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) begin
      n_passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    scan_en  = 1'b1;
    scan_out = b;
    step();
  endtask

  task automatic window(input logic [7:0] bits);
    for (int i = 0; i < 8; i++) shift_bit(bits[i]);
  endtask

  task automatic gap(input int n);
    scan_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start();
    scan_en = 1'b0;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    // Reset dominates start and scan_en
    rst = 1'b1; start = 1'b1; scan_en = 1'b1; scan_out = 1'b1;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err",  32'(err), 0);
    chk("rst_sig",  32'(signature), 32'h00);
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 10; i++) shift_bit(1'(i % 2));
    chk("idle_sig",  32'(signature), 32'h00);
    chk("idle_busy", 32'(busy), 0);

    // All-zero session, GOLDEN = 0
    do_start();
    chk("z_busy_start", 32'(busy), 1);
    chk("z_done_start", 32'(done), 0);
    for (int w = 0; w < 9; w++) begin
      if (w != 0) gap(1);
      if (w == 8) begin
        for (int i = 0; i < 7; i++) shift_bit(1'b0);
        chk("z_done_early", 32'(done), 0);
        chk("z_busy_early", 32'(busy), 1);
        shift_bit(1'b0);
      end else begin
        window(8'h00);
      end
    end
    chk("z_done", 32'(done), 1);
    chk("z_pass", 32'(pass), 1);
    chk("z_err",  32'(err), 0);
    chk("z_busy", 32'(busy), 0);
    chk("z_sig",  32'(signature), 32'h00);
    for (int i = 0; i < 10; i++) shift_bit(1'(i % 2));
    chk("z_done_held", 32'(done), 1);
    chk("z_pass_held", 32'(pass), 1);

    // Discard window 0, single-bit compaction, start pulses ignored mid-session
    do_start();
    chk("d_done_clr", 32'(done), 0);
    chk("d_pass_clr", 32'(pass), 0);
    chk("d_busy",     32'(busy), 1);
    window(8'hFF);
    gap(1);
    chk("d_sig_w0", 32'(signature), 32'h00);
    shift_bit(1'b1);
    chk("d_sig_b0", 32'(signature), 32'h1D);
    for (int i = 0; i < 7; i++) shift_bit(1'b0);
    gap(1);
    chk("d_sig_w1", 32'(signature), 32'h26);
    gap(3);
    chk("d_sig_hold",  32'(signature), 32'h26);
    chk("d_busy_hold", 32'(busy), 1);
    exp_sig = 8'h26;
    for (int w = 2; w <= 8; w++) begin
      for (int i = 0; i < 8; i++) begin
        start = (w == 2 && i == 3);
        shift_bit(1'b0);
        exp_sig = sisr(exp_sig, 1'b0);
      end
      start = 1'b0;
      if (w == 2) begin
        chk("d_sig_w2", 32'(signature), 32'(exp_sig));
        start = 1'b1;
      end
      if (w != 8) gap(1);
      start = 1'b0;
    end
    chk("d_done", 32'(done), 1);
    chk("d_pass", 32'(pass), 0);
    chk("d_err",  32'(err), 0);
    chk("d_sig",  32'(signature), 32'(exp_sig));

    // Protocol error: scan_en drops after 5 bits of window 2
    do_start();
    window(8'h3C);
    gap(2);
    pat = 8'hA5;
    exp_sig = 8'h00;
    for (int i = 0; i < 8; i++) begin
      shift_bit(pat[i]);
      exp_sig = sisr(exp_sig, pat[i]);
    end
    gap(1);
    pat = 8'h0B;
    for (int i = 0; i < 5; i++) begin
      shift_bit(pat[i]);
      exp_sig = sisr(exp_sig, pat[i]);
    end
    chk("e_err_before", 32'(err), 0);
    gap(1);
    chk("e_err",  32'(err), 1);
    chk("e_done", 32'(done), 1);
    chk("e_pass", 32'(pass), 0);
    chk("e_busy", 32'(busy), 0);
    chk("e_sig",  32'(signature), 32'(exp_sig));
    frozen = signature;
    window(8'h5A);
    chk("e_sig_frozen", 32'(signature), 32'(exp_sig));
    chk("e_err_held",   32'(err), 1);
    do_start();
    chk("e_err_clr", 32'(err), 0);
    chk("e_sig_clr", 32'(signature), 32'h00);

    // Reset in the middle of window 3
    window(8'h00);
    gap(1);
    window(8'hC3);
    gap(1);
    window(8'h81);
    gap(1);
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("r_busy", 32'(busy), 0);
    chk("r_done", 32'(done), 0);
    chk("r_pass", 32'(pass), 0);
    chk("r_err",  32'(err), 0);
    chk("r_sig",  32'(signature), 32'h00);
    for (int i = 0; i < 12; i++) shift_bit(1'b1);
    chk("r_sig_idle", 32'(signature), 32'h00);
    chk("r_busy_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
